// File: rtl/cadr_int_pkg.sv
// Shared types and helpers for the interrupt scheduler and other bus arbiters.
package cadr_int_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_PEND = 2'd2,
      ST_HOLD = 2'd3
   } int_state_e;

   localparam logic [7:0] VEC_BASE_DEF = 8'h40;
   localparam logic [7:0] SPUR_VEC_DEF = 8'h00;

   // Vector = base OR'ed with index*4; the caller truncates to its vector width.
   function automatic logic [31:0] build_vec(input logic [31:0] base, input logic [31:0] idx);
      return base | (idx << 2);
   endfunction

endpackage

// File: rtl/int_sched_if.sv
// Request / vector / acknowledge bundle between devices, microcode and the scheduler.
interface int_sched_if #(
   parameter int NREQ = 8,
   parameter int VECW = 8
);
   logic [NREQ-1:0] irq;
   logic [NREQ-1:0] irq_mask;
   logic            unibus_rst;
   logic            vec_rd;
   logic            sintr;
   logic [VECW-1:0] vec;
   logic [NREQ-1:0] irq_ack;
   logic            stuck_err;

   modport master (
      output irq, irq_mask, unibus_rst, vec_rd,
      input  sintr, vec, irq_ack, stuck_err
   );

   modport slave (
      input  irq, irq_mask, unibus_rst, vec_rd,
      output sintr, vec, irq_ack, stuck_err
   );
endinterface

// File: rtl/int_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module int_rr_pick #(
   parameter int NREQ = 8,
   parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [IDXW-1:0] grant,
   output logic            any
);

   logic [IDXW-1:0] idx_s;

   // Scan offsets from farthest to nearest so the nearest requester overwrites last.
   always_comb begin
      grant = '0;
      idx_s = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx_s = IDXW'((32'(ptr) + 32'(i)) % 32'(NREQ));
         grant = req[idx_s] ? idx_s : grant;
      end
      any = |req;
   end

endmodule

// File: rtl/int_sched.sv
// Interrupt request scheduler: synchronises and masks device requests, grants one
// by round-robin, presents its vector to microcode and tracks the device release.
module int_sched
   import cadr_int_pkg::*;
#(
   parameter int              NREQ        = 8,
   parameter int              VECW        = 8,
   parameter logic [VECW-1:0] VEC_BASE    = VECW'(VEC_BASE_DEF),
   parameter logic [VECW-1:0] SPUR_VEC    = VECW'(SPUR_VEC_DEF),
   parameter int              SYNC_STAGES = 2,
   parameter int              TMO_CYC     = 255
) (
   input  logic           clk,
   input  logic           reset,
   int_sched_if.slave     bus
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = 8;

   logic [NREQ-1:0] sync_q [SYNC_STAGES];
   logic [NREQ-1:0] sync_d [SYNC_STAGES];
   logic [NREQ-1:0] irq_s;
   logic [NREQ-1:0] req_s;
   logic [IDXW-1:0] grant_s;
   logic            any_s;

   int_state_e      state_q, state_d;
   logic [IDXW-1:0] win_q,   win_d;
   logic [IDXW-1:0] ptr_q,   ptr_d;
   logic [VECW-1:0] vec_q,   vec_d;
   logic            sintr_q, sintr_d;
   logic            spur_q,  spur_d;
   logic [CNTW-1:0] cnt_q,   cnt_d;
   logic            stuck_q, stuck_d;
   logic [NREQ-1:0] ack_q,   ack_d;

   assign irq_s = sync_q[SYNC_STAGES-1];
   assign req_s = irq_s & ~bus.irq_mask;

   int_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
      .req   (req_s),
      .ptr   (ptr_q),
      .grant (grant_s),
      .any   (any_s)
   );

   // Synchroniser shift chain.
   always_comb begin
      sync_d[0] = bus.irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Next-state logic; PEND/HOLD watch the raw synchronised line so a mask change
   // cannot withdraw a grant already made.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      vec_d   = vec_q;
      sintr_d = sintr_q;
      spur_d  = spur_q;
      cnt_d   = cnt_q;
      stuck_d = stuck_q;
      ack_d   = '0;
      if (bus.unibus_rst) begin
         state_d = ST_IDLE;
         sintr_d = 1'b0;
         vec_d   = '0;
         spur_d  = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req_s) begin
                  state_d = ST_ARB;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ARB: begin
               if (any_s) begin
                  win_d   = grant_s;
                  ptr_d   = (grant_s == IDXW'(NREQ - 1)) ? '0 : grant_s + IDXW'(1);
                  vec_d   = VECW'(build_vec(32'(VEC_BASE), 32'(grant_s)));
                  spur_d  = 1'b0;
                  sintr_d = 1'b1;
                  state_d = ST_PEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PEND: begin
               if (bus.vec_rd) begin
                  sintr_d = 1'b0;
                  if (spur_q) begin
                     spur_d  = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
                     cnt_d   = '0;
                     state_d = ST_HOLD;
                  end
               end else if (!irq_s[win_q]) begin
                  spur_d = 1'b1;
                  vec_d  = SPUR_VEC;
               end else begin
                  spur_d = spur_q;
               end
            end
            ST_HOLD: begin
               if (!irq_s[win_q]) begin
                  state_d = ST_IDLE;
               end else if (cnt_q == CNTW'(TMO_CYC)) begin
                  stuck_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         state_q <= ST_IDLE;
         win_q   <= '0;
         ptr_q   <= '0;
         vec_q   <= '0;
         sintr_q <= 1'b0;
         spur_q  <= 1'b0;
         cnt_q   <= '0;
         stuck_q <= 1'b0;
         ack_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         vec_q   <= vec_d;
         sintr_q <= sintr_d;
         spur_q  <= spur_d;
         cnt_q   <= cnt_d;
         stuck_q <= stuck_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.sintr     = sintr_q;
   assign bus.vec       = vec_q;
   assign bus.irq_ack   = ack_q;
   assign bus.stuck_err = stuck_q;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched: rotation table plus hand-written corner sequences.
module tb_int_sched;

   typedef struct {
      logic [7:0] irq;
      logic [7:0] mask;
      logic [7:0] exp_vec;
      logic [7:0] exp_ack;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl [10];

   always #5 clk = ~clk;

   int_sched_if #(.NREQ(8), .VECW(8)) bus ();

   int_sched #(
      .NREQ(8), .VECW(8), .VEC_BASE(8'h40), .SPUR_VEC(8'h00),
      .SYNC_STAGES(2), .TMO_CYC(255)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_sintr(input string name);
      int i = 0;
      while (bus.sintr !== 1'b1 && i < 30) begin
         @(negedge clk);
         i++;
      end
      check({name, " sintr"}, 32'(bus.sintr), 32'd1);
   endtask

   task automatic service(input string name, input logic [7:0] exp_vec, input logic [7:0] exp_ack);
      wait_sintr(name);
      check({name, " vec"}, 32'(bus.vec), 32'(exp_vec));
      check({name, " ack quiet"}, 32'(bus.irq_ack), 32'h0);
      bus.vec_rd = 1'b1;
      @(negedge clk);
      bus.vec_rd = 1'b0;
      check({name, " ack"}, 32'(bus.irq_ack), 32'(exp_ack));
      check({name, " sintr fall"}, 32'(bus.sintr), 32'd0);
      @(negedge clk);
      check({name, " ack 1cyc"}, 32'(bus.irq_ack), 32'h0);
   endtask

   initial begin
      // pointer starts at 0 after reset; each row raises all its bits at once
      tbl[0] = '{8'h81, 8'h00, 8'h40, 8'h01};
      tbl[1] = '{8'h81, 8'h00, 8'h5C, 8'h80};
      tbl[2] = '{8'h81, 8'h00, 8'h40, 8'h01};
      tbl[3] = '{8'h81, 8'h01, 8'h5C, 8'h80};
      tbl[4] = '{8'h81, 8'h01, 8'h5C, 8'h80};
      tbl[5] = '{8'h0C, 8'h00, 8'h48, 8'h04};
      tbl[6] = '{8'h0C, 8'h00, 8'h4C, 8'h08};
      tbl[7] = '{8'h30, 8'h10, 8'h54, 8'h20};
      tbl[8] = '{8'h42, 8'h00, 8'h58, 8'h40};
      tbl[9] = '{8'h42, 8'h00, 8'h44, 8'h02};

      reset          = 1'b1;
      bus.irq        = 8'h00;
      bus.irq_mask   = 8'h00;
      bus.unibus_rst = 1'b0;
      bus.vec_rd     = 1'b0;
      cyc(3);
      check("rst sintr", 32'(bus.sintr), 32'd0);
      check("rst vec", 32'(bus.vec), 32'h0);
      check("rst ack", 32'(bus.irq_ack), 32'h0);
      check("rst stuck", 32'(bus.stuck_err), 32'd0);
      reset = 1'b0;
      cyc(2);

      // vec_rd while idle does nothing
      bus.vec_rd = 1'b1;
      cyc(1);
      bus.vec_rd = 1'b0;
      check("idle rd ack", 32'(bus.irq_ack), 32'h0);
      check("idle rd sintr", 32'(bus.sintr), 32'd0);
      cyc(1);
      check("idle rd ack2", 32'(bus.irq_ack), 32'h0);

      // single request and latency: sintr appears after the 4th edge
      bus.irq = 8'h04;
      cyc(3);
      check("latency early", 32'(bus.sintr), 32'd0);
      cyc(1);
      check("latency", 32'(bus.sintr), 32'd1);
      service("t1", 8'h48, 8'h04);
      bus.irq = 8'h00;
      cyc(6);
      check("t1 idle sintr", 32'(bus.sintr), 32'd0);
      check("t1 idle ack", 32'(bus.irq_ack), 32'h0);

      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);

      for (int k = 0; k < 10; k++) begin
         bus.irq      = tbl[k].irq;
         bus.irq_mask = tbl[k].mask;
         service($sformatf("row%0d", k), tbl[k].exp_vec, tbl[k].exp_ack);
         bus.irq = 8'h00;
         cyc(6);
      end
      bus.irq_mask = 8'h00;

      // winner withdraws while pending: spurious vector, no acknowledge
      bus.irq = 8'h10;
      wait_sintr("t3");
      check("t3 vec", 32'(bus.vec), 32'h50);
      bus.irq = 8'h00;
      cyc(4);
      check("t3 spur vec", 32'(bus.vec), 32'h00);
      check("t3 spur sintr", 32'(bus.sintr), 32'd1);
      bus.vec_rd = 1'b1;
      cyc(1);
      bus.vec_rd = 1'b0;
      check("t3 no ack", 32'(bus.irq_ack), 32'h0);
      check("t3 sintr fall", 32'(bus.sintr), 32'd0);
      cyc(3);
      check("t3 no ack2", 32'(bus.irq_ack), 32'h0);
      check("t3 idle", 32'(bus.sintr), 32'd0);
      bus.irq = 8'h02;
      service("t3 next", 8'h44, 8'h02);
      bus.irq = 8'h00;
      cyc(6);

      // winner never releases: timeout sets sticky error and it is granted again
      bus.irq = 8'h01;
      service("t4", 8'h40, 8'h01);
      cyc(249);
      check("t4 stuck early", 32'(bus.stuck_err), 32'd0);
      check("t4 held sintr", 32'(bus.sintr), 32'd0);
      begin
         int i = 0;
         while (bus.stuck_err !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
         end
      end
      check("t4 stuck", 32'(bus.stuck_err), 32'd1);
      wait_sintr("t4 regrant");
      check("t4 regrant vec", 32'(bus.vec), 32'h40);

      // bus reset while pending
      bus.unibus_rst = 1'b1;
      cyc(1);
      bus.unibus_rst = 1'b0;
      check("t5 pend sintr", 32'(bus.sintr), 32'd0);
      check("t5 pend vec", 32'(bus.vec), 32'h0);
      check("t5 pend ack", 32'(bus.irq_ack), 32'h0);
      check("t5 stuck kept", 32'(bus.stuck_err), 32'd1);
      wait_sintr("t5 regrant");

      // bus reset while holding: must regrant long before the hold timeout
      bus.vec_rd = 1'b1;
      cyc(1);
      bus.vec_rd = 1'b0;
      check("t5 ack", 32'(bus.irq_ack), 32'h01);
      bus.unibus_rst = 1'b1;
      cyc(1);
      bus.unibus_rst = 1'b0;
      check("t5 hold sintr", 32'(bus.sintr), 32'd0);
      check("t5 hold ack", 32'(bus.irq_ack), 32'h0);
      check("t5 hold stuck", 32'(bus.stuck_err), 32'd1);
      wait_sintr("t5 left hold");
      check("t5 hold vec", 32'(bus.vec), 32'h40);

      // reset mid-pending clears everything and returns the pointer to 0
      reset   = 1'b1;
      bus.irq = 8'h81;
      cyc(1);
      check("t6 sintr", 32'(bus.sintr), 32'd0);
      check("t6 vec", 32'(bus.vec), 32'h0);
      check("t6 ack", 32'(bus.irq_ack), 32'h0);
      check("t6 stuck", 32'(bus.stuck_err), 32'd0);
      cyc(1);
      reset = 1'b0;
      wait_sintr("t6 regrant");
      check("t6 ptr zero", 32'(bus.vec), 32'h40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
